id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
- Decode-stage issue controller for the RISC-V pipeline. Sits between the IF/ID boundary and the decode datapath.
- Buffers fetched instructions in a small FIFO and presents one instruction at a time to decode.
- Configures the immediate generator: drives its 3-bit Type select from the opcode and its In[31:7] field from the instruction bits.
- Absorbs downstream stalls with a valid/ready handshake and discards all buffered work on a pipeline flush.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- PTR_W, 1, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered instructions (branch/jump redirect).
- in_valid  input  1  IF stage presents an instruction.
- in_inst  input  32  fetched instruction.
- in_pc  input  32  PC of in_inst.
- in_ready  output  1  FIFO can accept this cycle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_inst  output  32  head instruction.
- out_pc  output  32  head PC.
- imm_in  output  25  head instruction bits [31:7], routed to the immediate unit In.
- imm_type  output  3  immediate type select, using the `RTYPE/`ITYPE/`STYPE/`BTYPE/`UTYPE/`JTYPE macros from Parameters.v.
- illegal  output  1  head opcode is not recognised.
- issued_cnt  output  32  count of accepted pops.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: count=0, read and write pointers=0, issued_cnt=0, out_valid=0, in_ready=1.
- Outputs while empty:
  - out_inst=0, out_pc=0, imm_in=0, imm_type=`RTYPE, illegal=0.
  - imm_type and illegal are combinational from the head entry, gated by out_valid.
- Ready/valid:
  - in_ready = (count < DEPTH), computed from registered count only. When full, a same-cycle pop does not allow a push.
  - out_valid = (count != 0).
- Push: occurs when in_valid && in_ready. Data is written at write_ptr and write_ptr increments, wrapping modulo DEPTH.
- Pop: occurs when out_valid && out_ready. read_ptr increments (wrapping) and issued_cnt increments (wraps from 0xFFFFFFFF to 0).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no combinational in-to-out bypass.
- Priority:
  - rst over everything.
  - flush over push and pop. On flush, count and pointers go to 0, any same-cycle push is dropped, and any same-cycle pop is not counted. issued_cnt is kept.
  - flush while empty: no effect other than dropping a same-cycle push.
- Opcode to imm_type decode (inst[6:0]):
  - 0110011 -> `RTYPE
  - 0010011, 0000011, 1100111 -> `ITYPE
  - 0100011 -> `STYPE
  - 1100011 -> `BTYPE
  - 0110111, 0010111 -> `UTYPE
  - 1101111 -> `JTYPE
  - any other opcode -> `RTYPE with illegal=1
- Illegal entries are still issued normally; trap handling is downstream.
- Data stability: head outputs stay stable while out_valid && !out_ready. A push into a non-head slot does not disturb the head.

Test Plan:
- Reset then single push: rst for 2 cycles, then push inst=0x00500093 (addi x1,x0,5), pc=0x0 -> next cycle out_valid=1, imm_type=`ITYPE, imm_in=inst[31:7], illegal=0. Pop with out_ready=1 -> out_valid=0, issued_cnt=1.
- Fill and backpressure: out_ready=0, push 3 instructions back-to-back -> first two accepted (in_ready drops after the 2nd), third held by IF. Then out_ready=1 -> outputs pop in order pc 0x0, 0x4, 0x8; in_ready reasserts.
- Full with simultaneous pop: count=2, in_valid=1, out_ready=1 -> pop only, count=1. Push accepted the next cycle.
- Flush priority: count=2, in_valid=1, out_ready=1, flush=1 -> next cycle out_valid=0, count=0, issued_cnt unchanged, pushed instruction absent.
- Type coverage: push 0x00112023 (sw), 0x00000463 (beq), 0x123450B7 (lui), 0x0000006F (jal), 0xFFFFFFFF -> imm_type `STYPE, `BTYPE, `UTYPE, `JTYPE, `RTYPE with illegal=1, respectively.
- Counter wrap and mid-operation reset: force issued_cnt to 0xFFFFFFFF and pop -> 0. rst asserted with count=2 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue controller.
//   Buffers fetched instructions in a DEPTH-entry FIFO, presents the head to
//   decode with a valid/ready handshake, and configures the immediate unit.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            discard all buffered instructions (redirect)
//   in_valid/in_ready, in_inst, in_pc     IF-side push interface
//   out_valid/out_ready, out_inst, out_pc decode-side pop interface
//   imm_in           head inst[31:7] for the immediate unit
//   imm_type         immediate type select (R=0 I=1 S=2 B=3 U=4 J=5)
//   illegal          head opcode not recognised
//   issued_cnt       number of accepted pops (wrapping)
module id_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [24:0] imm_in,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic [31:0] issued_cnt
);

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]    mem_inst_q [DEPTH];
    logic [31:0]    mem_pc_q   [DEPTH];
    logic [PTR_W:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]    issued_q, issued_d;
    logic           push, pop;
    logic [31:0]    head_inst;
    imm_type_e      head_type;
    logic           head_illegal;

    // Readiness comes from registered count only: a full FIFO refuses a
    // push even when the head is being popped in the same cycle.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        issued_d = issued_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                issued_d = issued_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            issued_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_inst_q[wr_ptr_q] <= in_inst;
            mem_pc_q[wr_ptr_q]   <= in_pc;
        end
    end

    assign head_inst = mem_inst_q[rd_ptr_q];

    always_comb begin
        head_type    = IMM_R;
        head_illegal = 1'b0;
        case (head_inst[6:0])
            7'b0110011:                         head_type = IMM_R;
            7'b0010011, 7'b0000011, 7'b1100111: head_type = IMM_I;
            7'b0100011:                         head_type = IMM_S;
            7'b1100011:                         head_type = IMM_B;
            7'b0110111, 7'b0010111:             head_type = IMM_U;
            7'b1101111:                         head_type = IMM_J;
            default:                            head_illegal = 1'b1;
        endcase
    end

    assign out_inst   = out_valid ? head_inst : '0;
    assign out_pc     = out_valid ? mem_pc_q[rd_ptr_q] : '0;
    assign imm_in     = out_valid ? head_inst[31:7] : '0;
    assign imm_type   = out_valid ? head_type : IMM_R;
    assign illegal    = out_valid && head_illegal;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

    localparam int DEPTH = 2;
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2,
                           T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] out_inst, out_pc, issued_cnt;
    logic [24:0] imm_in;
    logic [2:0]  imm_type;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_issue_ctrl #(.DEPTH(DEPTH), .PTR_W(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .imm_in(imm_in), .imm_type(imm_type), .illegal(illegal), .issued_cnt(issued_cnt)
    );

    // ---------------- reference model: queue of {inst, pc} ----------------
    logic [63:0] m_q[$];
    logic [31:0] m_issued = '0;
    bit          m_live = 0;
    bit          wrap_req = 0;

    function automatic logic [3:0] exp_type(input logic [31:0] inst);
        // {illegal, type}
        case (inst[6:0])
            7'h33:             return {1'b0, T_R};
            7'h13, 7'h03, 7'h67: return {1'b0, T_I};
            7'h23:             return {1'b0, T_S};
            7'h63:             return {1'b0, T_B};
            7'h37, 7'h17:      return {1'b0, T_U};
            7'h6F:             return {1'b0, T_J};
            default:           return {1'b1, T_R};
        endcase
    endfunction

    always @(posedge clk) begin
        bit do_push, do_pop;
        logic [31:0] base;
        base = wrap_req ? 32'hFFFF_FFFF : m_issued;
        if (rst) begin
            m_q.delete();
            m_issued = '0;
            m_live = 1;
        end else if (flush) begin
            m_q.delete();
            m_issued = base;
        end else begin
            do_push = in_valid && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() != 0) && out_ready;
            if (do_pop) begin
                void'(m_q.pop_front());
                base = base + 32'd1;
            end
            if (do_push) m_q.push_back({in_inst, in_pc});
            m_issued = base;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle after the first reset edge
    always @(posedge clk) begin
        #1;
        if (m_live) begin
            logic [31:0] hi, hp;
            logic [3:0]  t;
            hi = (m_q.size() != 0) ? m_q[0][63:32] : '0;
            hp = (m_q.size() != 0) ? m_q[0][31:0]  : '0;
            t  = (m_q.size() != 0) ? exp_type(hi) : {1'b0, T_R};
            chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            chk("model_in_ready",  {31'd0, in_ready},  {31'd0, m_q.size() < DEPTH});
            chk("model_out_inst",  out_inst, hi);
            chk("model_out_pc",    out_pc, hp);
            chk("model_imm_in",    {7'd0, imm_in}, {7'd0, hi[31:7]});
            chk("model_imm_type",  {29'd0, imm_type}, {29'd0, t[2:0]});
            chk("model_illegal",   {31'd0, illegal}, {31'd0, t[3]});
            chk("model_issued",    issued_cnt, m_issued);
        end
    end

    // one cycle: drive at negedge, return after the edge has settled
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] tv_inst [5];
    logic [2:0]  tv_type [5];
    logic        tv_ill  [5];

    initial begin
        tv_inst[0] = 32'h0011_2023; tv_type[0] = T_S; tv_ill[0] = 1'b0;
        tv_inst[1] = 32'h0000_0463; tv_type[1] = T_B; tv_ill[1] = 1'b0;
        tv_inst[2] = 32'h1234_50B7; tv_type[2] = T_U; tv_ill[2] = 1'b0;
        tv_inst[3] = 32'h0000_006F; tv_type[3] = T_J; tv_ill[3] = 1'b0;
        tv_inst[4] = 32'hFFFF_FFFF; tv_type[4] = T_R; tv_ill[4] = 1'b1;

        // reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_issued",    issued_cnt, 32'd0);
        chk("rst_out_inst",  out_inst, 32'd0);

        // single push: addi x1,x0,5
        cyc(0, 0, 1, 32'h0050_0093, 32'h0, 0);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_type",  {29'd0, imm_type}, {29'd0, T_I});
        chk("addi_imm",   {7'd0, imm_in}, 32'h0000_A001);
        chk("addi_ill",   {31'd0, illegal}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("pop1_valid",  {31'd0, out_valid}, 32'd0);
        chk("pop1_issued", issued_cnt, 32'd1);

        // fill and backpressure
        cyc(0, 0, 1, 32'h0000_0013, 32'h0, 0);
        cyc(0, 0, 1, 32'h0000_0033, 32'h4, 0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        cyc(0, 0, 1, 32'h0000_0037, 32'h8, 0);
        chk("held_head_pc", out_pc, 32'h0);
        cyc(0, 0, 1, 32'h0000_0037, 32'h8, 1);   // full + pop: pop only
        chk("fullpop_pc",    out_pc, 32'h4);
        chk("fullpop_ready", {31'd0, in_ready}, 32'd1);
        cyc(0, 0, 1, 32'h0000_0037, 32'h8, 1);   // push+pop
        chk("pp_pc", out_pc, 32'h8);
        cyc(0, 0, 0, 0, 0, 1);
        chk("drain_valid",  {31'd0, out_valid}, 32'd0);
        chk("drain_issued", issued_cnt, 32'd4);

        // flush priority
        cyc(0, 0, 1, 32'h0000_0013, 32'h10, 0);
        cyc(0, 0, 1, 32'h0000_0013, 32'h14, 0);
        cyc(0, 1, 1, 32'h0000_006F, 32'h18, 1);
        chk("flush_valid",  {31'd0, out_valid}, 32'd0);
        chk("flush_issued", issued_cnt, 32'd4);
        cyc(0, 0, 0, 0, 0, 0);
        chk("flush_absent", {31'd0, out_valid}, 32'd0);
        cyc(0, 1, 1, 32'h0000_0013, 32'h1C, 0);  // flush while empty
        chk("flush_empty", {31'd0, out_valid}, 32'd0);

        // type coverage
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, tv_inst[i], 32'h100 + 32'(i * 4), 0);
            chk("type_sel", {29'd0, imm_type}, {29'd0, tv_type[i]});
            chk("type_ill", {31'd0, illegal}, {31'd0, tv_ill[i]});
            cyc(0, 0, 0, 0, 0, 1);
        end
        chk("type_issued", issued_cnt, 32'd9);

        // counter wrap
        cyc(0, 0, 1, 32'h0000_0013, 32'h200, 0);
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        force dut.issued_q = 32'hFFFF_FFFF;
        wrap_req = 1;
        #1 release dut.issued_q;
        @(posedge clk);
        #2;
        wrap_req = 0;
        chk("wrap_issued", issued_cnt, 32'd0);

        // mid-operation reset with count=2
        cyc(0, 0, 1, 32'h0000_0013, 32'h300, 0);
        cyc(0, 0, 1, 32'h0000_0013, 32'h304, 0);
        cyc(1, 0, 1, 32'h0000_0013, 32'h308, 1);
        chk("mrst_valid",  {31'd0, out_valid}, 32'd0);
        chk("mrst_ready",  {31'd0, in_ready}, 32'd1);
        chk("mrst_issued", issued_cnt, 32'd0);
        chk("mrst_inst",   out_inst, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
